// File: rtl/slc3_sram_arbiter.sv
// slc3_sram_arbiter: round-robin arbiter and access sequencer for the shared 16-bit SRAM.
// All SRAM pins are registered from next-state values, so nothing combinational reaches the pads.
module slc3_sram_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ready,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              port_q, port_d, we_q, we_d, last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d, cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;
   logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, bl_n_q, bl_n_d;
   logic              dq_oe_q, dq_oe_d, cpu_ready_q, cpu_ready_d, ldr_ready_q, ldr_ready_d;
   logic              grant_ldr;
   // port id 1 = loader; on a tie the loader wins unless it was granted last
   assign grant_ldr = ldr_req & (~cpu_req | ~last_q);
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      port_d      = port_q;
      we_d        = we_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      last_d      = last_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      ce_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      we_n_d      = 1'b1;
      bl_n_d      = 1'b1;
      dq_oe_d     = 1'b0;
      cpu_ready_d = 1'b0;
      ldr_ready_d = 1'b0;
      case (state_q)
         IDLE: if (cpu_req | ldr_req) begin
            state_d = SETUP;
            port_d  = grant_ldr;
            we_d    = grant_ldr ? ldr_we : cpu_we;
            addr_d  = grant_ldr ? ldr_addr : cpu_addr;
            dout_d  = grant_ldr ? ldr_wdata : cpu_wdata;
            ce_n_d  = 1'b0;
            bl_n_d  = 1'b0;
            oe_n_d  = we_d;
            dq_oe_d = we_d;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            ce_n_d  = 1'b0;
            bl_n_d  = 1'b0;
            oe_n_d  = we_q;
            we_n_d  = ~we_q;
            dq_oe_d = we_q;
         end
         ACCESS: begin
            ce_n_d  = 1'b0;
            bl_n_d  = 1'b0;
            oe_n_d  = we_q;
            dq_oe_d = we_q;
            if (cnt_q == 4'd0) begin
               state_d     = DONE;
               cpu_ready_d = ~port_q;
               ldr_ready_d = port_q;
               cpu_rdata_d = (!we_q && !port_q) ? sram_dq_in : cpu_rdata_q;
               ldr_rdata_d = (!we_q && port_q) ? sram_dq_in : ldr_rdata_q;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               we_n_d = ~we_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            last_d  = port_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         last_q      <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         bl_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         cpu_ready_q <= 1'b0;
         ldr_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         port_q      <= port_d;
         we_q        <= we_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         bl_n_q      <= bl_n_d;
         dq_oe_q     <= dq_oe_d;
         cpu_ready_q <= cpu_ready_d;
         ldr_ready_q <= ldr_ready_d;
      end
   end
   assign busy        = state_q != IDLE;
   assign cpu_ready   = cpu_ready_q;
   assign ldr_ready   = ldr_ready_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign ldr_rdata   = ldr_rdata_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dout_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign sram_ub_n   = bl_n_q;
   assign sram_lb_n   = bl_n_q;
endmodule

// File: tb/tb_slc3_sram_arbiter.sv
// tb_slc3_sram_arbiter: directed bench with a small SRAM model behind the arbiter.
module tb_slc3_sram_arbiter;
   logic        Clk, Reset;
   logic        cpu_req, cpu_we, ldr_req, ldr_we;
   logic [19:0] cpu_addr, ldr_addr, sram_addr;
   logic [15:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, sram_dq_out, sram_dq_in;
   logic        cpu_ready, ldr_ready, busy, sram_dq_oe;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   logic [15:0] mem [0:255];
   int          n_chk = 0, n_err = 0;

   slc3_sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ready(ldr_ready), .ldr_rdata(ldr_rdata),
      .busy(busy), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign sram_dq_in = mem[sram_addr[7:0]];
   always @(posedge Clk)
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_access(input bit is_ldr, input bit we, input logic [19:0] a,
                             input logic [15:0] d, output int lat);
      if (is_ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
      else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge Clk);
         if (is_ldr ? ldr_ready : cpu_ready) begin lat = i; break; end
      end
      cpu_req = 0;
      ldr_req = 0;
      @(negedge Clk);
   endtask

   function automatic logic [7:0] strobes();
      return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy, cpu_ready | ldr_ready};
   endfunction

   initial begin
      int lat, we_low, rdy, bad, n, t[4];
      bit who[4];
      Reset = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
      #3 Reset = 1;
      #1;
      check("reset_strobes", 32'(strobes()), 32'hF8);
      check("reset_rdata", {cpu_rdata, ldr_rdata}, 32'h0);
      check("reset_addr", 32'(sram_addr), 32'h0);
      @(negedge Clk);
      Reset = 0;
      @(negedge Clk);

      cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00010; cpu_wdata = 16'hBEEF;
      @(negedge Clk);
      check("wr_setup_ce_we", {sram_ce_n, sram_we_n, sram_dq_oe, busy}, 4'b0111);
      check("wr_setup_addr", 32'(sram_addr), 32'h10);
      we_low = 0; rdy = 0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge Clk);
         we_low += (sram_we_n == 0) ? 1 : 0;
         if (i < 3) rdy += cpu_ready ? 1 : 0;
         rdy += ldr_ready ? 1 : 0;
      end
      check("wr_we_low_cycles", we_low, 2);
      check("wr_cpu_ready_4th", cpu_ready, 1);
      check("wr_no_early_ready", rdy, 0);
      cpu_req = 0;
      @(negedge Clk);
      check("wr_idle_after", 32'(strobes()), 32'hF8);
      check("wr_mem", mem[8'h10], 16'hBEEF);

      cpu_req = 1; cpu_we = 0;
      bad = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge Clk);
         bad += (sram_oe_n || sram_dq_oe) ? 1 : 0;
      end
      check("rd_cpu_ready", cpu_ready, 1);
      check("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
      check("rd_oe_dq_oe", bad, 0);
      cpu_req = 0;
      @(negedge Clk);
      check("rd_rdata_hold", cpu_rdata, 16'hBEEF);
      check("rd_ldr_rdata", ldr_rdata, 16'h0);

      run_access(1, 1, 20'h00020, 16'h1111, lat);
      check("ldr_wr_lat", lat, 4);
      run_access(0, 1, 20'h00030, 16'h2222, lat);
      check("cpu_wr_lat", lat, 4);

      #2 Reset = 1;
      @(negedge Clk);
      Reset = 0;
      ldr_req = 1; ldr_we = 0; ldr_addr = 20'h00020;
      cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00030;
      n = 0; bad = 0;
      for (int c = 1; c <= 40 && n < 4; c++) begin
         @(negedge Clk);
         bad += (sram_dq_oe && !sram_oe_n) ? 1 : 0;
         if (cpu_ready && ldr_ready) bad++;
         if (cpu_ready || ldr_ready) begin
            t[n] = c; who[n] = ldr_ready; n++;
         end
      end
      cpu_req = 0; ldr_req = 0;
      check("rr_grants", n, 4);
      check("rr_order", {who[0], who[1], who[2], who[3]}, 4'b1010);
      check("rr_first_lat", t[0], 4);
      for (int i = 1; i < 4; i++) check("rr_gap", t[i] - t[i-1], 5);
      check("rr_exclusive", bad, 0);
      check("rr_rdata", {cpu_rdata, ldr_rdata}, 32'h2222_1111);
      @(negedge Clk);

      cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00040; cpu_wdata = 16'h5555;
      repeat (3) @(negedge Clk);
      check("rst_mid_we_low", sram_we_n, 0);
      #2 Reset = 1;
      #1;
      check("rst_mid_strobes", {sram_we_n, sram_ce_n, sram_dq_oe, busy}, 4'b1100);
      @(negedge Clk);
      Reset = 0; cpu_req = 0;
      rdy = 0;
      repeat (5) begin
         @(negedge Clk);
         rdy += (cpu_ready || ldr_ready) ? 1 : 0;
      end
      check("rst_mid_no_ready", rdy, 0);
      run_access(0, 0, 20'h00010, 16'h0, lat);
      check("rst_mid_rd_lat", lat, 4);
      check("rst_mid_rd_data", cpu_rdata, 16'hBEEF);

      run_access(1, 0, 20'h00020, 16'h0, lat);
      check("drop_pre_ldr", ldr_rdata, 16'h1111);
      cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00030;
      @(negedge Clk);
      cpu_req = 0;
      lat = -1; bad = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clk);
         bad += (ldr_rdata != 16'h1111) ? 1 : 0;
         if (cpu_ready) begin lat = i; break; end
      end
      check("drop_ready_lat", lat, 3);
      check("drop_cpu_rdata", cpu_rdata, 16'h2222);
      check("drop_ldr_stable", bad, 0);
      @(negedge Clk);
      check("drop_no_repeat", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/slc3_sram_arbiter.md
# slc3_sram_arbiter

Sequences the single off-chip 16-bit SRAM and shares it between two requesters: the SLC-3 CPU memory port and the program/test memory loader. It arbitrates with a round-robin policy, runs each access through a fixed setup/strobe/complete sequence with a parameterised wait-state count, and returns read data with a one-cycle ready pulse. It sits between the CPU and loader memory interfaces and the SRAM pins at the top level.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 2, strobe cycles per access (legal range 1..15)

- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- cpu_req / ldr_req  in  1  access request, held until the matching ready
- cpu_we / ldr_we  in  1  1 = write, 0 = read; stable while req is high
- cpu_addr / ldr_addr  in  ADDR_W  word address; stable while req is high
- cpu_wdata / ldr_wdata  in  DATA_W  write data; stable while req is high
- cpu_ready / ldr_ready  out  1  one-cycle completion pulse
- cpu_rdata / ldr_rdata  out  DATA_W  last read result for that port; held until that port's next read completes
- busy  out  1  high in every state except IDLE
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_out  out  DATA_W  write data to the DQ pad driver
- sram_dq_oe  out  1  DQ pad output enable
- sram_dq_in  in  DATA_W  DQ pad input
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1  active-low SRAM strobes

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: sample requests. With one request, grant it. With both, grant the port that was not granted most recently. last_grant resets to CPU, so the loader wins the first tie. With no request, remain in IDLE.
- On grant, latch the port id, we, addr, and wdata, then go to SETUP.
- SETUP (1 cycle): drive sram_addr; ce_n=0; ub_n=lb_n=0.
  - Read: oe_n=0.
  - Write: dq_oe=1, drive dq_out; we_n stays 1.
- ACCESS (WAIT_CYCLES cycles, internal down-counter):
  - Write: we_n=0 for all ACCESS cycles.
  - Read: oe_n stays 0; capture sram_dq_in on the last ACCESS cycle into the granted port's rdata register.
- DONE (1 cycle): pulse ready for the granted port only; we_n=1. Keep addr, dq_out, and dq_oe=1 (write) for hold time; ce_n=0. Update last_grant, then go to IDLE.
- IDLE outputs: all strobes 1, dq_oe=0. sram_addr and dq_out hold their last values.
- Dropping req mid-access: the access still completes and ready still pulses.
- Req still high in the cycle after ready: treated as a new request.
- Reset (async, any state): state=IDLE, all strobes=1, dq_oe=0, sram_addr=0, dq_out=0, both ready=0, both rdata=0, busy=0, last_grant=CPU. An in-flight access is abandoned and no ready is issued.
- sram_dq_oe and sram_oe_n are never both asserted in the same cycle.

## Timing
- Request sampled at edge E0 (IDLE), then:
  - SETUP in cycle E0..E1
  - ACCESS for E1..E1+W
  - DONE (ready high) for E1+W..E2+W
- Ready asserts WAIT_CYCLES+2 cycles after the sampling edge: 4 cycles at the default.
- Back-to-back accesses have exactly one IDLE cycle between DONE and the next SETUP. Throughput is one access per WAIT_CYCLES+3 cycles.
- rdata is valid in the same cycle as ready and holds afterward.
- Outputs are registered; there is no combinational path from the req inputs to the SRAM pins.

## Test plan
- Reset values: assert Reset mid-cycle. All strobes read 1 and dq_oe, busy, both ready, and both rdata read 0, asynchronously before the next edge.
- CPU write, W=2: cpu_req=1, we=1, addr=0x00010, wdata=0xBEEF.
  - SETUP cycle shows ce_n=0 and we_n=1.
  - we_n=0 for exactly 2 cycles.
  - cpu_ready pulses on the 4th cycle after the sampling edge; ldr_ready stays 0.
- CPU read back from the SRAM model at 0x00010: cpu_rdata=0xBEEF with cpu_ready, oe_n=0 throughout, dq_oe=0.
- Contention: both req held high after reset, loader addr 0x00020, CPU addr 0x00030.
  - Grants alternate loader, CPU, loader, CPU.
  - Each ready is separated by 5 cycles at W=2.
  - The non-granted port's ready stays 0.
- Reset mid-access: assert Reset during the second ACCESS cycle of a write. we_n and ce_n go to 1 immediately and no ready pulses. After release, a new read completes normally in 4 cycles.
- Dropped request: cpu_req deasserted during SETUP of a read. cpu_ready still pulses and cpu_rdata updates. ldr_rdata is unchanged throughout.
